// File: rtl/hi_lo_muldiv.sv
// hi_lo_muldiv: iterative multiply/divide unit owning the HI/LO registers.
// Operands are converted to magnitudes at start; 32 RUN cycles compute an
// unsigned product (shift-add, LSB first) or quotient/remainder (restoring,
// MSB first); FIX restores signs and writes HI/LO.
module hi_lo_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int LW = $clog2(WIDTH);
  localparam int CW = LW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t state, state_nxt;

  logic [1:0]         op_q;
  logic [WIDTH-1:0]   opa_q;     // |a|: multiplicand or dividend
  logic [WIDTH-1:0]   opb_q;     // |b|: multiplier or divisor
  logic [WIDTH-1:0]   a_raw_q;   // original a, returned in HI on divide by zero
  logic               neg_q_q;   // product / quotient sign
  logic               neg_r_q;   // remainder sign
  logic               dz_q;      // divide by zero
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q, done_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  // Operand conditioning at start: signed ops work on magnitudes.
  logic             sgn_op;
  logic [WIDTH-1:0] a_abs, b_abs;
  assign sgn_op = ~op[0];
  assign a_abs  = (sgn_op && a[WIDTH-1]) ? -a : a;
  assign b_abs  = (sgn_op && b[WIDTH-1]) ? -b : b;

  // One iteration of either algorithm, plus the FIX-stage sign correction.
  logic [LW-1:0]      bit_idx;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_acc;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] div_acc;
  logic [WIDTH-1:0]   hi_fix, lo_fix;
  logic [2*WIDTH-1:0] prod;

  // Datapath combinational step
  always_comb begin
    bit_idx   = cnt_q[LW-1:0];
    // Multiply: add multiplicand into the upper half, shift the pair right.
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                (opb_q[bit_idx] ? {1'b0, opa_q} : '0);
    mul_acc   = {mul_sum, acc_q[WIDTH-1:1]};
    // Divide: remainder in the upper half, quotient bits shift into the lower.
    div_shift = {acc_q[2*WIDTH-1:WIDTH], opa_q[~bit_idx]};
    div_ge    = div_shift >= {1'b0, opb_q};
    div_diff  = div_shift[WIDTH-1:0] - opb_q;
    div_acc   = {(div_ge ? div_diff : div_shift[WIDTH-1:0]),
                 acc_q[WIDTH-2:0], div_ge};
    // Sign correction
    prod      = neg_q_q ? -acc_q : acc_q;
    if (!op_q[1]) begin
      hi_fix = prod[2*WIDTH-1:WIDTH];
      lo_fix = prod[WIDTH-1:0];
    end else if (dz_q) begin
      hi_fix = a_raw_q;
      lo_fix = '1;
    end else begin
      hi_fix = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      lo_fix = neg_q_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (cnt_q == CW'(WIDTH-1)) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath, HI/LO and status registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      a_raw_q <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      dz_q    <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= (state == S_FIX);
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q    <= op;
            opa_q   <= a_abs;
            opb_q   <= b_abs;
            a_raw_q <= a;
            neg_q_q <= sgn_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r_q <= sgn_op & a[WIDTH-1];
            dz_q    <= op[1] & (b == '0);
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end else begin
            // Moves only land when no operation is being started.
            if (mthi) hi_q <= wdata;
            if (mtlo) lo_q <= wdata;
          end
        end
        S_RUN: begin
          acc_q <= op_q[1] ? div_acc : mul_acc;
          cnt_q <= cnt_q + CW'(1);
        end
        S_FIX: begin
          hi_q   <= hi_fix;
          lo_q   <= lo_fix;
          busy_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_hi_lo_muldiv.sv
// Bench for hi_lo_muldiv: directed plan cases plus randomized ops checked
// against an arithmetic reference model.
module tb_hi_lo_muldiv;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = '0, b = '0, wdata = '0;
  logic        mthi = 1'b0, mtlo = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  hi_lo_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .busy(busy), .done(done),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference: returns {HI, LO} from plain arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o,
                                        input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [31:0] uq, ur;
    sx = $signed(x);
    sy = $signed(y);
    case (o)
      2'd0: return 64'(sx * sy);
      2'd1: return {32'd0, x} * {32'd0, y};
      2'd2: begin
        if (y == 0) return {x, 32'hFFFFFFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFFFFFF};
        uq = x / y;
        ur = x % y;
        return {ur, uq};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'($urandom_range(0, 20));
      1: return 32'd0;
      2: return 32'h80000000;
      3: return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  // Issue one op (caller sits just after a negedge) and follow it to done.
  // disturb: pulse start/mthi/mtlo and change a/b during RUN.
  // with_mv: assert mthi/mtlo together with start.
  task automatic run_op(input logic [1:0] o, input logic [31:0] oa,
                        input logic [31:0] ob, input bit disturb,
                        input bit with_mv, input string name);
    logic [63:0] exp;
    logic [31:0] phi, plo;
    int n;
    exp = model(o, oa, ob);
    phi = hi;
    plo = lo;
    start = 1'b1; op = o; a = oa; b = ob;
    if (with_mv) begin mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0000DEAD; end
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s_accept busy=%b done=%b expected busy=1 done=0", name, busy, done);
    end
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (disturb && n == 5) begin
        start = 1'b1; op = 2'd1; a = 32'd2; b = 32'd3;
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0000DEAD;
      end
      if (disturb && n == 6) begin
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0; a = $urandom; b = $urandom;
      end
      if (n == 20) begin
        checks++;
        if (hi !== phi || lo !== plo || done !== 1'b0) begin
          errors++;
          $display("FAIL %s_midrun hi=%h lo=%h done=%b expected hi=%h lo=%h done=0",
                   name, hi, lo, done, phi, plo);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (n != 33) begin
      errors++;
      $display("FAIL %s_busy_cycles got %0d expected 33", name, n);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done got %b expected 1", name, done);
    end
    checks++;
    if (hi !== exp[63:32] || lo !== exp[31:0]) begin
      errors++;
      $display("FAIL %s_result op=%0d a=%h b=%h hi=%h lo=%h expected hi=%h lo=%h",
               name, o, oa, ob, hi, lo, exp[63:32], exp[31:0]);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset busy=%b done=%b hi=%h lo=%h expected all 0", busy, done, hi, lo);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_release busy=%b done=%b hi=%h lo=%h expected all 0",
               busy, done, hi, lo);
    end
  endtask

  task automatic test_directed();
    run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, "multu_max");
    checks++;
    if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
      errors++;
      $display("FAIL multu_max_const hi=%h lo=%h expected FFFFFFFE 00000001", hi, lo);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_single_pulse got %b expected 0", done);
    end
    run_op(2'd0, 32'hFFFFFFFD, 32'd7, 1'b0, 1'b0, "mult_neg");
    checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin
      errors++;
      $display("FAIL mult_neg_const hi=%h lo=%h expected FFFFFFFF FFFFFFEB", hi, lo);
    end
    @(negedge clk);
    run_op(2'd2, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, "div_neg");
    checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
      errors++;
      $display("FAIL div_neg_const hi=%h lo=%h expected FFFFFFFF FFFFFFFD", hi, lo);
    end
    @(negedge clk);
    run_op(2'd3, 32'd100, 32'd0, 1'b0, 1'b0, "divu_zero");
    checks++;
    if (hi !== 32'h00000064 || lo !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL divu_zero_const hi=%h lo=%h expected 00000064 FFFFFFFF", hi, lo);
    end
    @(negedge clk);
    run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, "div_wrap");
    checks++;
    if (hi !== 32'd0 || lo !== 32'h80000000) begin
      errors++;
      $display("FAIL div_wrap_const hi=%h lo=%h expected 00000000 80000000", hi, lo);
    end
    @(negedge clk);
    run_op(2'd2, 32'hFFFFFFF9, 32'd0, 1'b0, 1'b0, "div_zero_signed");
  endtask

  task automatic test_ignore_during_run();
    @(negedge clk);
    run_op(2'd3, 32'd100, 32'd7, 1'b1, 1'b0, "ignore");
    checks++;
    if (hi !== 32'd2 || lo !== 32'd14) begin
      errors++;
      $display("FAIL ignore_const hi=%h lo=%h expected 2 14", hi, lo);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_no_second_op done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  task automatic test_moves();
    mtlo = 1'b1; wdata = 32'h12345678;
    @(negedge clk);
    mtlo = 1'b0;
    checks++;
    if (lo !== 32'h12345678 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mtlo lo=%h busy=%b done=%b expected 12345678 0 0", lo, busy, done);
    end
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hCAFEF00D;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    checks++;
    if (hi !== 32'hCAFEF00D || lo !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL mthi_mtlo hi=%h lo=%h expected CAFEF00D CAFEF00D", hi, lo);
    end
    run_op(2'd1, 32'd4, 32'd5, 1'b0, 1'b1, "start_wins");
    checks++;
    if (hi !== 32'd0 || lo !== 32'd20) begin
      errors++;
      $display("FAIL start_wins_const hi=%h lo=%h expected 0 20", hi, lo);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    run_op(2'd0, 32'hFFFFFFF0, 32'h00001234, 1'b0, 1'b0, "b2b_0");
    run_op(2'd2, 32'h7FFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0, "b2b_1");
    run_op(2'd3, 32'hFFFFFFFF, 32'h00000010, 1'b0, 1'b0, "b2b_2");
    @(negedge clk);
  endtask

  task automatic test_reset_midop();
    start = 1'b1; op = 2'd0; a = 32'd6; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_midop busy=%b done=%b hi=%h lo=%h expected all 0",
               busy, done, hi, lo);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_op(2'd1, 32'd6, 32'd7, 1'b0, 1'b0, "after_reset");
    checks++;
    if (lo !== 32'd42 || hi !== 32'd0) begin
      errors++;
      $display("FAIL after_reset_const hi=%h lo=%h expected 0 42", hi, lo);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 50; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = pick();
      rb = pick();
      run_op(ro, ra, rb, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), "rand");
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_during_run();
    test_moves();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
